// File: rtl/demux32bit_1to2_buf_if.sv
// Bus bundle for the buffered 1-to-2 steering unit: one valid/ready input
// channel with a destination select, and two valid/ready output channels.
interface demux32bit_1to2_buf_if;
  localparam int unsigned DW = 32;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          select;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out1_data;

  modport master (
    output in_valid, in_data, select, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, select, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux32bit_1to2_buf.sv
// Buffered 1-to-2 demux: each accepted word goes to a 2-entry FIFO chosen by select.
// Optional macro DEMUX_STRICT_ORDER_EN keeps global program order across both outputs.
module demux32bit_1to2_buf (
  input logic                   clk,
  input logic                   reset,
  demux32bit_1to2_buf_if.slave  bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned NF = 2;
  localparam int unsigned DEPTH = 2;

  // Per-FIFO occupancy doubles as the 0..2 entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  fifo_state_t   state_q [NF];
  fifo_state_t   state_d [NF];
  logic [NF-1:0] rd_q, rd_d;
  logic [NF-1:0] wr_q, wr_d;
  logic [DW-1:0] mem_q [NF][DEPTH];

  logic [NF-1:0] out_valid;
  logic [NF-1:0] out_ready;
  logic [NF-1:0] push;
  logic [NF-1:0] pop;
  logic          sel_ready_c;
  logic          order_ok_c;
  logic          in_ready_c;
  logic          accept_c;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // Handshake decode and next-state for both FIFOs.
  always_comb begin
    out_valid   = '0;
    push        = '0;
    pop         = '0;
    rd_d        = rd_q;
    wr_d        = wr_q;
    sel_ready_c = 1'b0;
    order_ok_c  = 1'b1;
    in_ready_c  = 1'b0;
    accept_c    = 1'b0;
    for (int i = 0; i < NF; i++) begin
      state_d[i]   = state_q[i];
      out_valid[i] = (state_q[i] != EMPTY);
    end

    sel_ready_c = (state_q[bus.select] != FULL) || out_ready[bus.select];
`ifdef DEMUX_STRICT_ORDER_EN
    // The other side must be empty or draining its last word this cycle.
    order_ok_c = (state_q[~bus.select] == EMPTY) ||
                 ((state_q[~bus.select] == HALF) && out_ready[~bus.select]);
`else
    order_ok_c = 1'b1;
`endif
    in_ready_c = !reset && sel_ready_c && order_ok_c;
    accept_c   = bus.in_valid && in_ready_c;

    for (int i = 0; i < NF; i++) begin
      push[i] = accept_c && (bus.select == 1'(i));
      pop[i]  = out_valid[i] && out_ready[i] && !reset;
      if (push[i]) wr_d[i] = ~wr_q[i];
      if (pop[i])  rd_d[i] = ~rd_q[i];
      case ({push[i], pop[i]})
        2'b10:   state_d[i] = (state_q[i] == EMPTY) ? HALF : FULL;
        2'b01:   state_d[i] = (state_q[i] == FULL) ? HALF : EMPTY;
        default: state_d[i] = state_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NF; i++) state_q[i] <= EMPTY;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      for (int i = 0; i < NF; i++) state_q[i] <= state_d[i];
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // Storage is datapath only; empty FIFOs are masked on the output side.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = out_valid[0];
  assign bus.out1_valid = out_valid[1];
  assign bus.out0_data  = out_valid[0] ? mem_q[0][rd_q[0]] : '0;
  assign bus.out1_data  = out_valid[1] ? mem_q[1][rd_q[1]] : '0;
endmodule

// File: tb/tb_demux32bit_1to2_buf.sv
// Self-checking bench for demux32bit_1to2_buf with per-output scoreboard queues.
module tb_demux32bit_1to2_buf;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   mon_en;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  demux32bit_1to2_buf_if bus ();

  demux32bit_1to2_buf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: inputs and outputs are stable at the falling edge, so the
  // handshakes seen here are the ones that complete at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        exp_ready;
      logic [31:0] d;
      int          sz_sel;
      int          sz_oth;
      logic        rdy_sel;
      logic        rdy_oth;
      sz_sel  = bus.select ? exp1.size() : exp0.size();
      sz_oth  = bus.select ? exp0.size() : exp1.size();
      rdy_sel = bus.select ? bus.out1_ready : bus.out0_ready;
      rdy_oth = bus.select ? bus.out0_ready : bus.out1_ready;
      exp_ready = !reset && ((sz_sel < 2) || rdy_sel);
`ifdef DEMUX_STRICT_ORDER_EN
      exp_ready = exp_ready && ((sz_oth == 0) || ((sz_oth == 1) && rdy_oth));
`endif
      checks++;
      if (bus.in_ready !== exp_ready) begin
        failures++;
        $display("FAIL in_ready t=%0t got=%b exp=%b", $time, bus.in_ready, exp_ready);
      end
      checks++;
      if (bus.out0_valid !== (exp0.size() != 0)) begin
        failures++;
        $display("FAIL out0_valid t=%0t got=%b exp=%b", $time, bus.out0_valid, exp0.size() != 0);
      end
      checks++;
      if (bus.out1_valid !== (exp1.size() != 0)) begin
        failures++;
        $display("FAIL out1_valid t=%0t got=%b exp=%b", $time, bus.out1_valid, exp1.size() != 0);
      end
      if (exp0.size() == 0) begin
        checks++;
        if (bus.out0_data !== 32'h0) begin
          failures++;
          $display("FAIL out0_data_empty t=%0t got=%h exp=0", $time, bus.out0_data);
        end
      end
      if (exp1.size() == 0) begin
        checks++;
        if (bus.out1_data !== 32'h0) begin
          failures++;
          $display("FAIL out1_data_empty t=%0t got=%h exp=0", $time, bus.out1_data);
        end
      end
      if (reset) begin
        exp0.delete();
        exp1.delete();
      end else begin
        if (exp0.size() != 0 && bus.out0_ready) begin
          d = exp0.pop_front();
          checks++;
          if (bus.out0_data !== d) begin
            failures++;
            $display("FAIL out0_order t=%0t got=%h exp=%h", $time, bus.out0_data, d);
          end
        end
        if (exp1.size() != 0 && bus.out1_ready) begin
          d = exp1.pop_front();
          checks++;
          if (bus.out1_data !== d) begin
            failures++;
            $display("FAIL out1_order t=%0t got=%h exp=%h", $time, bus.out1_data, d);
          end
        end
        if (bus.in_valid && exp_ready) begin
          if (bus.select) exp1.push_back(bus.in_data);
          else            exp0.push_back(bus.in_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 20) begin
      step();
      n++;
    end
    step();
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d/%0d words left exp=0/0", name, exp0.size(), exp1.size());
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'hA5A5_0001;
    bus.select     = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    step();
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b v0=%b v1=%b exp 0 0 0",
               bus.in_ready, bus.out0_valid, bus.out1_valid);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL first_word got v=%b d=%h exp v=1 d=a5a50001", bus.out0_valid, bus.out0_data);
    end
    drain("reset");
  endtask

  task automatic test_fill_stall();
    logic [31:0] words [3];
    words[0] = 32'h11;
    words[1] = 32'h22;
    words[2] = 32'h33;
    bus.out1_ready = 1'b0;
    bus.select     = 1'b1;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = words[i];
      @(negedge clk);
      checks++;
      if (bus.in_ready !== (i < 2)) begin
        failures++;
        $display("FAIL fill_ready_%0d got=%b exp=%b", i, bus.in_ready, i < 2);
      end
      step();
    end
    bus.out1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out1_data !== 32'h11) begin
      failures++;
      $display("FAIL stall_release got rdy=%b d=%h exp rdy=1 d=00000011", bus.in_ready, bus.out1_data);
    end
    step();
    bus.in_valid = 1'b0;
    drain("fill_stall");
  endtask

  task automatic test_push_pop_full();
    bus.out1_ready = 1'b0;
    bus.select     = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'h11;
    step();
    bus.in_data = 32'h22;
    step();
    bus.in_data    = 32'h33;
    bus.out1_ready = 1'b1;
    step();
    bus.in_valid   = 1'b0;
    bus.out1_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out1_data !== 32'h22 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_full got d=%h rdy=%b exp d=00000022 rdy=0", bus.out1_data, bus.in_ready);
    end
    bus.out1_ready = 1'b1;
    step();
    bus.out1_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out1_data !== 32'h33 || bus.out1_valid !== 1'b1) begin
      failures++;
      $display("FAIL push_pop_next got d=%h v=%b exp d=00000033 v=1", bus.out1_data, bus.out1_valid);
    end
    drain("push_pop_full");
  endtask

`ifdef DEMUX_STRICT_ORDER_EN
  task automatic test_strict_order();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b1;
    bus.select     = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'hC0DE_0000;
    step();
    bus.select  = 1'b1;
    bus.in_data = 32'hC0DE_0001;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL strict_block got=%b exp=0", bus.in_ready);
    end
    step();
    bus.out0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL strict_handoff got=%b exp=1", bus.in_ready);
    end
    step();
    bus.in_valid   = 1'b0;
    bus.out1_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_data !== 32'hC0DE_0001) begin
      failures++;
      $display("FAIL strict_after got v0=%b d1=%h exp v0=0 d1=c0de0001", bus.out0_valid, bus.out1_data);
    end
    drain("strict");
  endtask
`else
  task automatic test_independence();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b1;
    bus.select     = 1'b0;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_data = 32'hB000_0000 + 32'(i);
      step();
    end
    bus.select = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 32'hD000_0000 + 32'(i);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out0_valid !== 1'b1) begin
        failures++;
        $display("FAIL indep_%0d got rdy=%b v0=%b exp 1 1", i, bus.in_ready, bus.out0_valid);
      end
      step();
    end
    drain("indep");
  endtask
`endif

  task automatic test_reset_mid();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    bus.in_valid   = 1'b1;
    bus.select     = 1'b0;
    bus.in_data    = 32'hE000_0000;
    step();
    bus.in_data = 32'hE000_0001;
    step();
`ifndef DEMUX_STRICT_ORDER_EN
    bus.select  = 1'b1;
    bus.in_data = 32'hE000_0002;
    step();
`endif
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    step();
    reset          = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 ||
        bus.out0_data !== 32'h0 || bus.out1_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid got v0=%b v1=%b d0=%h d1=%h exp all 0",
               bus.out0_valid, bus.out1_valid, bus.out0_data, bus.out1_data);
    end
    for (int i = 0; i < 3; i++) step();
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.select     = 1'($urandom_range(0, 1));
      bus.in_data    = $urandom;
      bus.out0_ready = ($urandom_range(0, 2) != 0);
      bus.out1_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain("b2b");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    test_reset();
    test_fill_stall();
    test_push_pop_full();
`ifdef DEMUX_STRICT_ORDER_EN
    test_strict_order();
`else
    test_independence();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
